// File: rtl/run_ctrl_seq.sv
// Run-control sequencer: core reset pulse, cycle/fetch counters, EBREAK halt and fetch watchdog.
// Optional fetch-PC history ring buffer enabled by defining RUN_CTRL_PC_HIST_EN.
module run_ctrl_seq #(
    parameter int          XLEN        = 64,
    parameter int          CNT_W       = 32,
    parameter int          RST_CYCLES  = 4,
    parameter int          WDOG_CYCLES = 256,
    parameter logic [31:0] HALT_INSTR  = 32'h00100073
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ir_write,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
`ifdef RUN_CTRL_PC_HIST_EN
    input  logic [1:0]       hist_idx,
    output logic [XLEN-1:0]  hist_pc,
`endif
    output logic             core_rst,
    output logic             running,
    output logic             halted,
    output logic             timeout,
    output logic [XLEN-1:0]  halt_pc,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int RC_W = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES + 1)  : 1;
    localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;

    localparam logic [RC_W-1:0]  RST_LOAD = RC_W'(RST_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        HALT,
        TIMEOUT
    } state_t;

    state_t           state, state_n;
    logic [RC_W-1:0]  rst_cnt, rst_cnt_n;
    logic [WD_W-1:0]  wdog, wdog_n;
    logic [CNT_W-1:0] cycle_count_n, instr_count_n;
    logic [XLEN-1:0]  halt_pc_n;
    logic             start_run;
    logic             fetch;

    // A run may only be (re)started from a resting state; start is ignored in RESET and RUN.
    assign start_run = start && ((state == IDLE) || (state == HALT) || (state == TIMEOUT));
    assign fetch     = (state == RUN) && ir_write;

    always_comb begin
        state_n       = state;
        rst_cnt_n     = rst_cnt;
        wdog_n        = wdog;
        cycle_count_n = cycle_count;
        instr_count_n = instr_count;
        halt_pc_n     = halt_pc;

        case (state)
            IDLE, HALT, TIMEOUT: begin
                if (start_run) begin
                    state_n       = RESET;
                    rst_cnt_n     = RST_LOAD;
                    wdog_n        = '0;
                    cycle_count_n = '0;
                    instr_count_n = '0;
                    halt_pc_n     = '0;
                end
            end

            RESET: begin
                if (rst_cnt == '0) begin
                    state_n = RUN;
                end else begin
                    rst_cnt_n = rst_cnt - RC_W'(1);
                end
            end

            RUN: begin
                if (cycle_count != CNT_MAX) begin
                    cycle_count_n = cycle_count + CNT_W'(1);
                end
                // A fetch always beats watchdog expiry in the same cycle.
                if (ir_write) begin
                    wdog_n = '0;
                    if (instr_count != CNT_MAX) begin
                        instr_count_n = instr_count + CNT_W'(1);
                    end
                    if (instr == HALT_INSTR) begin
                        halt_pc_n = pc;
                        state_n   = HALT;
                    end
                end else if (wdog == WD_LAST) begin
                    state_n = TIMEOUT;
                end else begin
                    wdog_n = wdog + WD_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            wdog        <= '0;
            cycle_count <= '0;
            instr_count <= '0;
            halt_pc     <= '0;
            core_rst    <= 1'b1;
            running     <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            wdog        <= wdog_n;
            cycle_count <= cycle_count_n;
            instr_count <= instr_count_n;
            halt_pc     <= halt_pc_n;
            core_rst    <= (state_n != RUN);
            running     <= (state_n == RUN);
            halted      <= (state_n == HALT);
            timeout     <= (state_n == TIMEOUT);
        end
    end

`ifdef RUN_CTRL_PC_HIST_EN
    logic [XLEN-1:0] hist_mem [4];
    logic [1:0]      hist_wptr;

    // The write pointer sits one past the newest entry; cleared entries read as zero.
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            hist_wptr <= '0;
            for (int i = 0; i < 4; i++) begin
                hist_mem[i] <= '0;
            end
        end else if (fetch) begin
            hist_mem[hist_wptr] <= pc;
            hist_wptr           <= hist_wptr + 2'd1;
        end
    end

    assign hist_pc = hist_mem[hist_wptr - 2'd1 - hist_idx];
`endif

endmodule
